rf_wb_arbiter: RTL

Write-back arbiter and scoreboard for the 16 x 16-bit register file. It shares the file's single write port (WriteReg/DstReg/DstData) between two write-back sources: requester 0 is the ALU and requester 1 is the load unit. Each source gets a one-entry buffer behind a valid/ready handshake. The block also tracks a per-register busy bit so issue logic can stall on pending destinations. It sits between the execute/memory stages and the register file.

---
 rtl/rf_pkg.sv | 28 ++
 rtl/rf_wb_slot.sv | 38 +++
 rtl/rf_wb_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back path.
// Holds the data/register widths, the requester index constants and the
// write-back entry type carried through the per-requester slots.
package rf_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int REG_W    = 4;

  // Requester indices into grant / busy-clear bookkeeping
  localparam int REQ_ALU = 0;
  localparam int REQ_LD  = 1;

  // One buffered write-back: destination register and value
  typedef struct packed {
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // One-hot decode of a register index
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_W-1:0] r);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry valid/ready buffer for a single write-back requester.
// The slot accepts a new entry when it is empty or when it is being drained
// at the same edge, so an uncontended requester streams at one per cycle.
module rf_wb_slot
  import rf_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  wb_entry_t in_entry,
  input  logic      drain,
  output logic      full,
  output wb_entry_t entry
);

  logic      full_q;
  wb_entry_t entry_q;

  // Ready depends only on slot state and the current grant, never on in_valid
  assign in_ready = !full_q || drain;
  assign full     = full_q;
  assign entry    = entry_q;

  // Load on handshake (refill wins over drain), otherwise empty when drained
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else if (in_valid && in_ready) begin
      full_q  <= 1'b1;
      entry_q <= in_entry;
    end else if (drain) begin
      full_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and busy scoreboard in front of the register file's
// single write port. Requester 0 is the ALU, requester 1 is the load unit.
//
// Handshake: a transfer on reqN happens at a rising edge where reqN_valid and
// reqN_ready are both high. reqN_ready never depends on reqN_valid; it is high
// when the slot is empty or the slot is granted this cycle. Once valid is
// raised the requester holds reg/data stable until the transfer.
//
// Build option RF_WB_RR_EN: when defined, two full slots are served
// round-robin via a 1-bit last-grant pointer; when undefined the load unit
// always wins a contended cycle and the pointer does not exist.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS,
  parameter int REG_W    = rf_pkg::REG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [REG_W-1:0]    req0_reg,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [REG_W-1:0]    req1_reg,
  input  logic [DATA_W-1:0]   req1_data,
  input  logic                rsv_valid,
  input  logic [REG_W-1:0]    rsv_reg,
  output logic [NUM_REGS-1:0] busy,
  output logic                rf_we,
  output logic [REG_W-1:0]    rf_dst,
  output logic [DATA_W-1:0]   rf_data,
  output logic [1:0]          grant
);

  wb_entry_t in0, in1;
  wb_entry_t slot0_entry, slot1_entry;
  wb_entry_t sel_entry;
  logic      full0, full1;
  logic [1:0] grant_c;

  logic                rf_we_q;
  logic [REG_W-1:0]    rf_dst_q;
  logic [DATA_W-1:0]   rf_data_q;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  assign in0 = '{wreg: req0_reg, data: req0_data};
  assign in1 = '{wreg: req1_reg, data: req1_data};

  rf_wb_slot u_slot_alu (
    .clk      (clk),
    .rst      (rst),
    .in_valid (req0_valid),
    .in_ready (req0_ready),
    .in_entry (in0),
    .drain    (grant_c[REQ_ALU]),
    .full     (full0),
    .entry    (slot0_entry)
  );

  rf_wb_slot u_slot_ld (
    .clk      (clk),
    .rst      (rst),
    .in_valid (req1_valid),
    .in_ready (req1_ready),
    .in_entry (in1),
    .drain    (grant_c[REQ_LD]),
    .full     (full1),
    .entry    (slot1_entry)
  );

`ifdef RF_WB_RR_EN
  // High when the load unit received the most recent grant
  logic last_ld_q;

  // Round-robin: a contended cycle goes to the requester not granted last
  always_comb begin
    grant_c = 2'b00;
    if (full0 && full1) begin
      if (last_ld_q) grant_c[REQ_ALU] = 1'b1;
      else           grant_c[REQ_LD]  = 1'b1;
    end else if (full0) begin
      grant_c[REQ_ALU] = 1'b1;
    end else if (full1) begin
      grant_c[REQ_LD] = 1'b1;
    end
  end

  // Pointer moves only on a grant; reset value makes the ALU win first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ld_q <= 1'b1;
    end else if (grant_c != 2'b00) begin
      last_ld_q <= grant_c[REQ_LD];
    end
  end
`else
  // Fixed priority: the load unit wins whenever its slot is full
  always_comb begin
    grant_c = 2'b00;
    if (full1) begin
      grant_c[REQ_LD] = 1'b1;
    end else if (full0) begin
      grant_c[REQ_ALU] = 1'b1;
    end
  end
`endif

  assign grant     = grant_c;
  assign sel_entry = grant_c[REQ_LD] ? slot1_entry : slot0_entry;

  // Output register: the granted entry is presented to the register file
  // next cycle; R0 targets update dst/data but never raise the write enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q   <= 1'b0;
      rf_dst_q  <= '0;
      rf_data_q <= '0;
    end else if (grant_c != 2'b00) begin
      rf_we_q   <= (sel_entry.wreg != '0);
      rf_dst_q  <= sel_entry.wreg;
      rf_data_q <= sel_entry.data;
    end else begin
      rf_we_q   <= 1'b0;
    end
  end

  // Busy next state: clear on the write the register file captures, then
  // apply a new reservation so a same-register set overrides the clear
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d = busy_d & ~reg_mask(rf_dst_q);
    end
    if (rsv_valid && (rsv_reg != '0)) begin
      busy_d = busy_d | reg_mask(rsv_reg);
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_dst  = rf_dst_q;
  assign rf_data = rf_data_q;
  assign busy    = busy_q;

endmodule
